// File: rtl/huffman_pkg.sv
// Shared Huffman encoder definitions: packer FSM states and the message bit-count width.
package huffman_pkg;

  typedef enum logic [1:0] {
    PACK  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } packer_state_t;

  localparam int unsigned TOTAL_BIT_W = 11;

endpackage

// File: rtl/huffman_bit_packer.sv
// Packs variable-length Huffman codewords MSB-first into BIT_WIDTH-bit words,
// with flush/zero-pad of the final word and a saturating message bit count.
module huffman_bit_packer
  import huffman_pkg::*;
#(
  parameter  int unsigned BIT_WIDTH    = 8,
  parameter  int unsigned MAX_CODE_LEN = 15,
  localparam int unsigned LEN_W        = $clog2(MAX_CODE_LEN + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   code_valid_i,
  output logic                   code_ready_o,
  input  logic [MAX_CODE_LEN-1:0] code_i,
  input  logic [LEN_W-1:0]       code_len_i,
  input  logic                   flush_i,
  output logic                   word_valid_o,
  input  logic                   word_ready_i,
  output logic [BIT_WIDTH-1:0]   word_o,
  output logic                   word_last_o,
  output logic                   done_o,
  output logic [TOTAL_BIT_W-1:0] bit_count_o
);

  localparam int unsigned ACC_W  = BIT_WIDTH + MAX_CODE_LEN;
  localparam int unsigned FILL_W = $clog2(ACC_W + 1);

  packer_state_t          state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   flush_pend_q, flush_pend_d;
  logic                   restart_q, restart_d;
  logic [TOTAL_BIT_W-1:0] bit_count_q, bit_count_d;

  logic [MAX_CODE_LEN-1:0] code_mask;
  logic [ACC_W-1:0]        code_ext;
  logic [FILL_W-1:0]       app_sh;
  logic [TOTAL_BIT_W:0]    cnt_sum;
  logic                    accept;
  logic                    word_hs;
  logic                    fill_le_word;

  // Output decode from state and fill; bits past fill are always zero, giving the pad.
  assign fill_le_word = (fill_q <= FILL_W'(BIT_WIDTH));
  assign code_ready_o = (state_q == PACK) && fill_le_word;
  assign word_valid_o = ((state_q == PACK) && !fill_le_word) ||
                        ((state_q == FLUSH) && (fill_q != '0));
  assign word_last_o  = (state_q == FLUSH) && fill_le_word;
  assign word_o       = acc_q[ACC_W-1 -: BIT_WIDTH];
  assign done_o       = (state_q == DONE);
  assign bit_count_o  = bit_count_q;

  assign accept    = code_valid_i && code_ready_o;
  assign word_hs   = word_valid_o && word_ready_i;
  assign code_mask = ~({MAX_CODE_LEN{1'b1}} << code_len_i);
  assign code_ext  = ACC_W'(code_i & code_mask);
  assign app_sh    = FILL_W'(ACC_W) - fill_q - FILL_W'(code_len_i);
  assign cnt_sum   = {1'b0, bit_count_q} + (TOTAL_BIT_W + 1)'(code_len_i);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    flush_pend_d = flush_pend_q;
    restart_d    = restart_q;
    bit_count_d  = bit_count_q;
    case (state_q)
      PACK: begin
        if (word_hs) begin
          acc_d  = acc_q << BIT_WIDTH;
          fill_d = fill_q - FILL_W'(BIT_WIDTH);
        end
        if (accept) begin
          acc_d     = acc_q | (code_ext << app_sh);
          fill_d    = fill_q + FILL_W'(code_len_i);
          restart_d = 1'b0;
          if (restart_q) begin
            bit_count_d = TOTAL_BIT_W'(code_len_i);
          end else if (cnt_sum[TOTAL_BIT_W]) begin
            bit_count_d = '1;
          end else begin
            bit_count_d = cnt_sum[TOTAL_BIT_W-1:0];
          end
        end
        // A flush seen while stalled waits until the accumulator can take codes again.
        if (code_ready_o && (flush_i || flush_pend_q)) begin
          flush_pend_d = 1'b0;
          state_d      = (fill_d == '0) ? DONE : FLUSH;
        end else if (!code_ready_o && flush_i) begin
          flush_pend_d = 1'b1;
        end
      end
      FLUSH: begin
        if (word_hs) begin
          if (word_last_o) begin
            acc_d   = '0;
            fill_d  = '0;
            state_d = DONE;
          end else begin
            acc_d  = acc_q << BIT_WIDTH;
            fill_d = fill_q - FILL_W'(BIT_WIDTH);
          end
        end
      end
      DONE: begin
        restart_d = 1'b1;
        state_d   = PACK;
      end
      default: state_d = PACK;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= PACK;
      acc_q        <= '0;
      fill_q       <= '0;
      flush_pend_q <= 1'b0;
      restart_q    <= 1'b0;
      bit_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_pend_q <= flush_pend_d;
      restart_q    <= restart_d;
      bit_count_q  <= bit_count_d;
    end
  end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Bench for huffman_bit_packer: bit-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_huffman_bit_packer;

  localparam int BW = 8;
  localparam int ML = 15;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        code_valid_i;
  logic        code_ready_o;
  logic [14:0] code_i;
  logic [3:0]  code_len_i;
  logic        flush_i;
  logic        word_valid_o;
  logic        word_ready_i;
  logic [7:0]  word_o;
  logic        word_last_o;
  logic        done_o;
  logic [10:0] bit_count_o;

  huffman_bit_packer #(.BIT_WIDTH(BW), .MAX_CODE_LEN(ML)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .code_valid_i(code_valid_i), .code_ready_o(code_ready_o),
    .code_i(code_i), .code_len_i(code_len_i), .flush_i(flush_i),
    .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .word_o(word_o), .word_last_o(word_last_o),
    .done_o(done_o), .bit_count_o(bit_count_o)
  );

  always #5 clk = ~clk;

  // Reference: pending message bits in order, plus phase 0=packing 1=flushing 2=done.
  bit   mq[$];
  int   mode;
  bit   pend;
  int   cnt;
  bit   restart;
  logic [7:0] dut_words[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic bit e_ready();
    return (mode == 0) && (mq.size() <= BW);
  endfunction
  function automatic bit e_valid();
    return ((mode == 0) && (mq.size() > BW)) || ((mode == 1) && (mq.size() > 0));
  endfunction
  function automatic bit e_last();
    return (mode == 1) && (mq.size() <= BW);
  endfunction
  function automatic int e_word();
    int w = 0;
    for (int i = 0; i < BW; i++) w = (w << 1) | ((i < mq.size()) ? int'(mq[i]) : 0);
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    mode = 0; pend = 0; cnt = 0; restart = 0;
  endtask

  task automatic model_step(input bit cv, input logic [14:0] c, input int l,
                            input bit fl, input bit wr);
    bit rdy = e_ready();
    bit vld = e_valid();
    bit lst = e_last();
    case (mode)
      0: begin
        if (vld && wr) repeat (BW) void'(mq.pop_front());
        if (rdy && cv) begin
          for (int i = l - 1; i >= 0; i--) mq.push_back(c[i]);
          cnt = restart ? l : ((cnt + l > 2047) ? 2047 : cnt + l);
          restart = 0;
        end
        if (rdy && (fl || pend)) begin
          pend = 0;
          mode = (mq.size() == 0) ? 2 : 1;
        end else if (!rdy && fl) begin
          pend = 1;
        end
      end
      1: begin
        if (vld && wr) begin
          if (lst) begin mq.delete(); mode = 2; end
          else repeat (BW) void'(mq.pop_front());
        end
      end
      default: begin mode = 0; restart = 1; end
    endcase
  endtask

  task automatic compare();
    chk("code_ready", int'(code_ready_o), int'(e_ready()));
    chk("word_valid", int'(word_valid_o), int'(e_valid()));
    chk("word_last",  int'(word_last_o),  int'(e_last()));
    chk("done",       int'(done_o),       int'(mode == 2));
    chk("word",       int'(word_o),       e_word());
    chk("bit_count",  int'(bit_count_o),  cnt);
  endtask

  // One clock: drive at negedge, step model at posedge, compare at next negedge.
  task automatic cycle(input bit cv, input logic [14:0] c, input int l,
                       input bit fl, input bit wr);
    code_valid_i = cv; code_i = c; code_len_i = 4'(l);
    flush_i = fl; word_ready_i = wr;
    #1;
    if (word_valid_o && word_ready_i) dut_words.push_back(word_o);
    @(posedge clk);
    model_step(cv, c, l, fl, wr);
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    cycle(1'b0, 15'd0, 0, 1'b0, 1'b1);
  endtask

  task automatic send_code(input logic [14:0] c, input int l);
    bit took = 0;
    for (int k = 0; k < 30 && !took; k++) begin
      took = e_ready();
      cycle(1'b1, c, l, 1'b0, 1'b1);
    end
    if (!took) timeout("send_code");
  endtask

  task automatic do_flush();
    cycle(1'b0, 15'd0, 0, 1'b1, 1'b1);
    for (int k = 0; k < 30 && !done_o; k++) idle();
    if (!done_o) timeout("flush_done");
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; code_valid_i = 1'b0; code_i = '0; code_len_i = '0;
    flush_i = 1'b0; word_ready_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(code_ready_o), 1);
    chk("rst_valid", int'(word_valid_o), 0);
    chk("rst_last",  int'(word_last_o), 0);
    chk("rst_done",  int'(done_o), 0);
    chk("rst_word",  int'(word_o), 0);
    chk("rst_count", int'(bit_count_o), 0);
    rst_i = 1'b0;

    // Empty flush: no word, done next cycle.
    cycle(1'b0, 15'd0, 0, 1'b1, 1'b1);
    chk("empty_done", int'(done_o), 1);
    chk("empty_valid", int'(word_valid_o), 0);
    chk("empty_count", int'(bit_count_o), 0);
    idle();

    // Single full word held back until the flush.
    dut_words.delete();
    cycle(1'b1, 15'b101, 3, 1'b0, 1'b1);
    cycle(1'b1, 15'b11,  2, 1'b0, 1'b1);
    cycle(1'b1, 15'b010, 3, 1'b0, 1'b1);
    chk("sw_held", int'(word_valid_o), 0);
    cycle(1'b0, 15'd0, 0, 1'b1, 1'b1);
    chk("sw_valid", int'(word_valid_o), 1);
    chk("sw_word", int'(word_o), 'hBA);
    chk("sw_last", int'(word_last_o), 1);
    idle();
    chk("sw_done", int'(done_o), 1);
    chk("sw_count", int'(bit_count_o), 8);
    idle();
    chk("sw_nwords", dut_words.size(), 1);

    // Long codes.
    dut_words.delete();
    send_code(15'h7FFF, 15);
    chk("long_stall", int'(code_ready_o), 0);
    send_code(15'h7FFF, 15);
    do_flush();
    chk("long_count", int'(bit_count_o), 30);
    idle();
    chk("long_nwords", dut_words.size(), 4);
    if (dut_words.size() == 4) begin
      chk("long_w0", int'(dut_words[0]), 'hFF);
      chk("long_w1", int'(dut_words[1]), 'hFF);
      chk("long_w2", int'(dut_words[2]), 'hFF);
      chk("long_w3", int'(dut_words[3]), 'hFC);
    end

    // Backpressure with a word pending.
    dut_words.delete();
    cycle(1'b1, 15'hA5, 8, 1'b0, 1'b0);
    cycle(1'b1, 15'h3,  4, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 15'hF, 4, 1'b0, 1'b0);
      chk("bp_word", int'(word_o), 'hA5);
      chk("bp_last", int'(word_last_o), 0);
      chk("bp_ready", int'(code_ready_o), 0);
    end
    cycle(1'b1, 15'hF, 4, 1'b0, 1'b1);
    send_code(15'hF, 4);
    do_flush();
    idle();
    chk("bp_nwords", dut_words.size(), 2);
    if (dut_words.size() == 2) begin
      chk("bp_w0", int'(dut_words[0]), 'hA5);
      chk("bp_w1", int'(dut_words[1]), 'h3F);
    end

    // Code and flush in the same cycle.
    cycle(1'b1, 15'h1, 1, 1'b1, 1'b1);
    chk("sim_word", int'(word_o), 'h80);
    chk("sim_last", int'(word_last_o), 1);
    idle();
    chk("sim_done", int'(done_o), 1);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 1)), 15'($urandom), int'($urandom_range(0, 15)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end

    // Reset in the middle of FLUSH.
    @(negedge clk);
    apply_reset();
    cycle(1'b1, 15'hAB, 8, 1'b0, 1'b0);
    cycle(1'b0, 15'd0, 0, 1'b1, 1'b0);
    chk("rf_in_flush", int'(word_last_o), 1);
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("rf_valid", int'(word_valid_o), 0);
    chk("rf_done", int'(done_o), 0);
    @(negedge clk);
    rst_i = 1'b0;
    idle();
    chk("rf_ready", int'(code_ready_o), 1);
    chk("rf_count", int'(bit_count_o), 0);
    idle();
    chk("rf_nodone", int'(done_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_bit_packer.md
# huffman_bit_packer

Downstream stage of the Huffman encoder: consumes variable-length codewords (code bits plus length) produced by the encoder core and packs them MSB-first into fixed-width output words. A valid/ready handshake runs on both sides. A flush request zero-pads the final partial word, marks it last, and pulses a done flag. The block also reports the running message bit count, on the same 11-bit scale as the encoder's `total_bit`.

## Interface
- `BIT_WIDTH`, default 8: output word width.
- `MAX_CODE_LEN`, default 15: maximum codeword length. `LEN_W = $clog2(MAX_CODE_LEN+1)`.
- `clk_i`  in  1: the block's single clock.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `code_valid_i`  in  1: codeword offered.
- `code_ready_o`  out  1: codeword accepted when both valid and ready are high.
- `code_i`  in  MAX_CODE_LEN: codeword, right-justified. Bit `len-1` is sent first.
- `code_len_i`  in  LEN_W: codeword length, 0..MAX_CODE_LEN.
- `flush_i`  in  1: end-of-message pulse.
- `word_valid_o`  out  1: packed word available.
- `word_ready_i`  in  1: consumer accepts the word.
- `word_o`  out  BIT_WIDTH: packed word. The first bit is in the MSB.
- `word_last_o`  out  1: final word of the message.
- `done_o`  out  1: one-cycle pulse when the message is complete.
- `bit_count_o`  out  11: code bits accepted in the current or last message.

## Operation
- **Accumulator:** `acc` has width `ACC_W = BIT_WIDTH+MAX_CODE_LEN`. `fill` counts valid bits, 0..ACC_W. Valid bits are left-aligned at `acc[ACC_W-1]`.
- **States:** PACK (reset state), FLUSH, DONE.
- **PACK:**
  - `code_ready_o = (fill <= BIT_WIDTH)`.
  - On accept, append `code_i[len-1:0]` immediately after the valid bits, then `fill += len`. `len=0` is accepted and changes nothing.
  - `word_valid_o = (fill > BIT_WIDTH)`. A full word (exactly `BIT_WIDTH` bits) is held back so it can be flagged last.
  - Accept and emit are mutually exclusive by construction. `fill` never exceeds ACC_W.
- **Word handshake:** on a word handshake, shift `acc` left by `BIT_WIDTH` and set `fill -= BIT_WIDTH`.
- **`flush_i` sampling:** sampled only in PACK.
  - If `flush_i` is high while `code_ready_o` is low, it is latched in `flush_pend` and honoured once `code_ready_o` rises.
  - If a code is accepted in the same cycle as `flush_i`, the code is appended first.
- **Flush entry:**
  - If `fill == 0` after the append: go directly to DONE.
  - Otherwise: go to FLUSH.
- **FLUSH:**
  - `code_ready_o = 0`. `word_valid_o = (fill > 0)`.
  - `word_o = acc[ACC_W-1 -: BIT_WIDTH]`. Bits beyond `fill` read as 0, which gives the zero padding.
  - `word_last_o = (fill <= BIT_WIDTH)`.
  - After the handshake of the last word, set `fill = 0`, clear `acc`, and go to DONE.
- **DONE:** `done_o = 1` for exactly one cycle, then PACK. `code_ready_o = 0` in DONE.
- **bit_count_o:**
  - Adds `len` on every accept and saturates at 2047.
  - Holds through FLUSH and DONE.
  - The first accept after DONE reloads it with `len` rather than adding.
- **Word stability:** while `word_valid_o && !word_ready_i`, `word_o` and `word_last_o` must hold steady.

## Timing
- **Register-driven outputs:** all outputs are decoded from registers. There are no combinational paths from inputs to outputs.
- **Word latency:** a codeword accepted at edge N that makes `fill > BIT_WIDTH` raises `word_valid_o` in cycle N+1.
- **Flush latency:**
  - A flush sampled at edge N raises `word_valid_o` with `word_last_o` in cycle N+1.
  - A flush with nothing to emit raises `done_o` in cycle N+1.
- **Done latency:** `done_o` is high in the cycle after the edge on which the last word handshakes.
- **Throughput:** one word per cycle while draining.
- **Reset:** while `rst_i` is high, the block is in PACK with `acc`, `fill`, `flush_pend` and `bit_count_o` all at 0.
  - Output values during reset: `word_valid_o=0`, `word_last_o=0`, `done_o=0`, `word_o=0`, `bit_count_o=0`, `code_ready_o=1`.
  - Reset mid-FLUSH abandons the message. No `done_o` pulse is produced.

## Structure
- **Shared package `huffman_pkg`:** holds the state enum `packer_state_t` (PACK, FLUSH, DONE) and the constant `TOTAL_BIT_W = 11`.
- **`ACC_W` and `LEN_W`:** local parameters derived in the module.
- **Hierarchy:** single module with no sub-module. The append (variable shift-or) and the drain (fixed shift) are written inline.

## Test plan
- **Single full word:** codes (3'b101, 3), (2'b11, 2), (3'b010, 3), then `flush_i`. Required: no word before the flush; then `word_o=8'hBA` with `word_last_o=1`; `done_o` pulse; `bit_count_o=8`.
- **Long codes:** two codes of 15'h7FFF with length 15, then flush. Required: words 8'hFF, 8'hFF, 8'hFF, then 8'hFC with last=1; `bit_count_o=30`; `code_ready_o` is low while `fill > 8`.
- **Backpressure:** `word_ready_i=0` for 5 cycles with a word pending. Required: `word_o`/`word_last_o` stable, `code_ready_o=0`, and no word lost or duplicated after release.
- **Simultaneous code and flush:** code (1'b1, 1) in the same cycle as `flush_i`. Required: `word_o=8'h80`, last=1, then `done_o`.
- **Empty flush:** `flush_i` with `fill=0`. Required: no word; `done_o` pulses in the next cycle; `bit_count_o=0`.
- **Reset mid-FLUSH:** assert `rst_i` during FLUSH. Required: `word_valid_o` and `done_o` go to 0 immediately; after release, `code_ready_o=1` and `bit_count_o=0`.
